// File: rtl/lab3_qsys_ram_stream_reader.sv
// Streams a window of on-chip RAM words out as one Avalon-ST packet.
// Optional abort input is enabled with `define RAM_STREAM_ABORT_EN.
module lab3_qsys_ram_stream_reader #(
    parameter int unsigned ADDR_W = 14,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 10000
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] length,
`ifdef RAM_STREAM_ABORT_EN
    input  logic              abort,
`endif
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [3:0]        mem_byteenable,
    output logic              mem_clken,
    input  logic [DATA_W-1:0] mem_readdata,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_sop,
    output logic              out_eop
);

    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] AddrOne  = ADDR_W'(1);

    typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

    state_e            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] len_q;
    logic [ADDR_W-1:0] issue_left_q;
    logic [ADDR_W-1:0] beat_cnt_q;
    logic              inflight_q;
    logic [DATA_W-1:0] fifo_q [2];
    logic              wr_ptr_q;
    logic              rd_ptr_q;
    logic [1:0]        count_q;
    logic              done_q;

    logic              pop;
    logic              push;
    logic              issue;
    logic              last_beat;
    logic [2:0]        occ;

    assign mem_write      = 1'b0;
    assign mem_byteenable = 4'hF;
    assign mem_clken      = 1'b1;

    assign out_valid = (count_q != 2'd0);
    assign out_data  = fifo_q[rd_ptr_q];
    assign out_sop   = out_valid && (beat_cnt_q == '0);
    assign out_eop   = out_valid && (beat_cnt_q == len_q - AddrOne);

    assign pop       = out_valid && out_ready;
    assign push      = inflight_q;
    assign last_beat = pop && (beat_cnt_q == len_q - AddrOne);

    // Occupancy after this cycle's pop, counting the read already in flight; keeps the
    // 2-entry FIFO from overflowing while still allowing one beat per cycle.
    assign occ = {1'b0, count_q} + {2'b0, inflight_q} - {2'b0, pop};

    assign busy           = (state_q != StIdle);
    assign mem_address    = addr_q;
    assign mem_chipselect = issue;

`ifdef RAM_STREAM_ABORT_EN
    logic abort_req;
    assign abort_req = abort && (state_q != StIdle);
    assign issue     = (state_q == StRun) && (occ < 3'd2) && !abort_req;
    assign done      = done_q || ((state_q == StDrain) && last_beat && !abort_req);
`else
    assign issue     = (state_q == StRun) && (occ < 3'd2);
    assign done      = done_q || ((state_q == StDrain) && last_beat);
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            addr_q       <= '0;
            len_q        <= '0;
            issue_left_q <= '0;
            beat_cnt_q   <= '0;
            inflight_q   <= 1'b0;
            fifo_q[0]    <= '0;
            fifo_q[1]    <= '0;
            wr_ptr_q     <= 1'b0;
            rd_ptr_q     <= 1'b0;
            count_q      <= 2'd0;
            done_q       <= 1'b0;
        end else begin
            done_q     <= 1'b0;
            inflight_q <= issue;
            count_q    <= count_q + {1'b0, push} - {1'b0, pop};

            // RAM data returns exactly one cycle after the read was issued.
            if (push) begin
                fifo_q[wr_ptr_q] <= mem_readdata;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q   <= ~rd_ptr_q;
                beat_cnt_q <= beat_cnt_q + AddrOne;
            end
            if (issue) begin
                addr_q       <= (addr_q == LastAddr) ? '0 : addr_q + AddrOne;
                issue_left_q <= issue_left_q - AddrOne;
            end

            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        if (length != '0) begin
                            addr_q       <= base_addr;
                            len_q        <= length;
                            issue_left_q <= length;
                            beat_cnt_q   <= '0;
                            state_q      <= StRun;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                StRun: begin
                    if (issue && (issue_left_q == AddrOne)) begin
                        state_q <= StDrain;
                    end
                end
                StDrain: begin
                    if (last_beat) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase

`ifdef RAM_STREAM_ABORT_EN
            // Drop queued and in-flight data so out_valid falls on the next cycle.
            if (abort_req) begin
                state_q    <= StIdle;
                done_q     <= 1'b1;
                inflight_q <= 1'b0;
                count_q    <= 2'd0;
                wr_ptr_q   <= 1'b0;
                rd_ptr_q   <= 1'b0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_lab3_qsys_ram_stream_reader.sv
// Directed bench for lab3_qsys_ram_stream_reader with a one-cycle-latency RAM model.
module tb_lab3_qsys_ram_stream_reader;

    localparam int unsigned ADDR_W = 14;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned DEPTH  = 10000;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [ADDR_W-1:0] length = '0;
    logic              abort = 1'b0;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] mem_address;
    logic              mem_chipselect;
    logic              mem_write;
    logic [3:0]        mem_byteenable;
    logic              mem_clken;
    logic [DATA_W-1:0] mem_readdata;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic              out_sop;
    logic              out_eop;

    logic [DATA_W-1:0] rd_q = '0;

    int checks = 0;
    int errors = 0;

    logic [DATA_W-1:0] beat_data [$];
    logic              beat_sop  [$];
    logic              beat_eop  [$];
    int                beat_cyc  [$];
    logic [ADDR_W-1:0] rd_addr   [$];
    int                done_cnt;
    int                done_cyc;
    int                max_out;
    int                stall_viol;
    logic              busy_after;
    int                quiet_hits;

    always #5 clk = ~clk;

    lab3_qsys_ram_stream_reader #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .DEPTH (DEPTH)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .start         (start),
        .base_addr     (base_addr),
        .length        (length),
`ifdef RAM_STREAM_ABORT_EN
        .abort         (abort),
`endif
        .busy          (busy),
        .done          (done),
        .mem_address   (mem_address),
        .mem_chipselect(mem_chipselect),
        .mem_write     (mem_write),
        .mem_byteenable(mem_byteenable),
        .mem_clken     (mem_clken),
        .mem_readdata  (mem_readdata),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_sop       (out_sop),
        .out_eop       (out_eop)
    );

    function automatic logic [DATA_W-1:0] ram_word(input logic [ADDR_W-1:0] a);
        return 32'hA000_0000 | {18'h0, a};
    endfunction

    always_ff @(posedge clk) begin
        if (mem_chipselect) rd_q <= ram_word(mem_address);
    end
    assign mem_readdata = rd_q;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Starts a transfer and logs reads, beats and done until a few cycles past done.
    // Cycle 0 is the first cycle after the edge that accepts start.
    task automatic run_xfer(input logic [ADDR_W-1:0] b, input logic [ADDR_W-1:0] l,
                            input bit rnd, input bit poke);
        int          issued;
        int          moved;
        logic        prev_stall;
        logic [DATA_W-1:0] prev_data;
        logic        prev_sop;
        logic        prev_eop;
        beat_data.delete(); beat_sop.delete(); beat_eop.delete();
        beat_cyc.delete(); rd_addr.delete();
        done_cnt = 0; done_cyc = -1; max_out = 0; stall_viol = 0; busy_after = 1'bx;
        issued = 0; moved = 0; prev_stall = 1'b0;
        prev_data = '0; prev_sop = 1'b0; prev_eop = 1'b0;
        @(negedge clk);
        start = 1'b1; base_addr = b; length = l; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 0; cyc < 80; cyc++) begin
            if (cyc > 0) @(negedge clk);
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (poke && cyc == 3) begin
                start = 1'b1; base_addr = 14'd5; length = 14'd2;
            end else begin
                start = 1'b0;
            end
            #1;
            if (prev_stall && (out_data !== prev_data || out_sop !== prev_sop ||
                               out_eop !== prev_eop)) stall_viol++;
            if (mem_chipselect) begin
                rd_addr.push_back(mem_address);
                issued++;
            end
            if (out_valid && out_ready) begin
                beat_data.push_back(out_data);
                beat_sop.push_back(out_sop);
                beat_eop.push_back(out_eop);
                beat_cyc.push_back(cyc);
                moved++;
            end
            if (issued - moved > max_out) max_out = issued - moved;
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (done_cyc >= 0 && cyc == done_cyc + 1) busy_after = busy;
            prev_stall = out_valid && !out_ready;
            prev_data = out_data; prev_sop = out_sop; prev_eop = out_eop;
            if (done_cyc >= 0 && cyc >= done_cyc + 3) break;
        end
        start = 1'b0;
        out_ready = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_sop_eop", 64'({out_sop, out_eop}), 64'd0);
        check("rst_cs", 64'(mem_chipselect), 64'd0);
        check("rst_data", 64'(out_data), 64'd0);
        check("rst_addr", 64'(mem_address), 64'd0);
        check("ties", 64'({mem_write, mem_byteenable, mem_clken}), 64'b0_1111_1);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // Basic 4-word packet at full throughput
        run_xfer(14'd0, 14'd4, 1'b0, 1'b0);
        check("b4_nbeats", 64'(beat_data.size()), 64'd4);
        check("b4_nreads", 64'(rd_addr.size()), 64'd4);
        for (int i = 0; i < 4 && i < beat_data.size(); i++) begin
            check("b4_data", 64'(beat_data[i]), 64'(ram_word(14'(i))));
            check("b4_cycle", 64'(beat_cyc[i]), 64'(2 + i));
            check("b4_sop", 64'(beat_sop[i]), 64'(i == 0));
            check("b4_eop", 64'(beat_eop[i]), 64'(i == 3));
        end
        check("b4_done_cnt", 64'(done_cnt), 64'd1);
        check("b4_done_cyc", 64'(done_cyc), 64'd5);
        check("b4_busy_after", 64'(busy_after), 64'd0);

        // Address wrap at the top of the RAM
        run_xfer(14'd9998, 14'd4, 1'b0, 1'b0);
        check("wrap_nreads", 64'(rd_addr.size()), 64'd4);
        if (rd_addr.size() == 4) begin
            check("wrap_a0", 64'(rd_addr[0]), 64'd9998);
            check("wrap_a1", 64'(rd_addr[1]), 64'd9999);
            check("wrap_a2", 64'(rd_addr[2]), 64'd0);
            check("wrap_a3", 64'(rd_addr[3]), 64'd1);
        end
        check("wrap_nbeats", 64'(beat_data.size()), 64'd4);
        if (beat_data.size() == 4) begin
            check("wrap_d1", 64'(beat_data[1]), 64'h0000_0000_A000_270F);
            check("wrap_d2", 64'(beat_data[2]), 64'h0000_0000_A000_0000);
        end

        // Random backpressure, plus a start while busy that must be ignored
        run_xfer(14'd100, 14'd8, 1'b1, 1'b1);
        check("bp_nbeats", 64'(beat_data.size()), 64'd8);
        check("bp_nreads", 64'(rd_addr.size()), 64'd8);
        for (int i = 0; i < 8 && i < beat_data.size(); i++) begin
            check("bp_data", 64'(beat_data[i]), 64'(ram_word(14'(100 + i))));
            check("bp_sop", 64'(beat_sop[i]), 64'(i == 0));
            check("bp_eop", 64'(beat_eop[i]), 64'(i == 7));
        end
        check("bp_max_out", 64'(max_out <= 2), 64'd1);
        check("bp_stable", 64'(stall_viol), 64'd0);
        check("bp_done_cnt", 64'(done_cnt), 64'd1);

        // Zero length: done only, no reads, no beats
        run_xfer(14'd7, 14'd0, 1'b0, 1'b0);
        check("z_nreads", 64'(rd_addr.size()), 64'd0);
        check("z_nbeats", 64'(beat_data.size()), 64'd0);
        check("z_done_cnt", 64'(done_cnt), 64'd1);
        check("z_done_cyc", 64'(done_cyc), 64'd0);

        // Single word: sop and eop on the same beat
        run_xfer(14'd42, 14'd1, 1'b0, 1'b0);
        check("one_nbeats", 64'(beat_data.size()), 64'd1);
        if (beat_data.size() == 1) begin
            check("one_data", 64'(beat_data[0]), 64'h0000_0000_A000_002A);
            check("one_sop_eop", 64'({beat_sop[0], beat_eop[0]}), 64'b11);
            check("one_cycle", 64'(beat_cyc[0]), 64'd2);
        end
        check("one_done_cyc", 64'(done_cyc), 64'd2);

        // Reset after beat 2 of 6
        @(negedge clk);
        start = 1'b1; base_addr = 14'd0; length = 14'd6; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("mid_beat2", 64'({out_valid, out_data}), {31'd0, 1'b1, ram_word(14'd1)});
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("mid_rst_ctrl", 64'({busy, done, out_valid, out_sop, out_eop, mem_chipselect}),
              64'd0);
        check("mid_rst_data", 64'(out_data), 64'd0);
        check("mid_rst_addr", 64'(mem_address), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        quiet_hits = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            if (done || out_valid || mem_chipselect || busy) quiet_hits++;
        end
        check("post_rst_quiet", 64'(quiet_hits), 64'd0);

`ifdef RAM_STREAM_ABORT_EN
        // Abort on beat 3 of 10, then a fresh transfer
        @(negedge clk);
        start = 1'b1; base_addr = 14'd0; length = 14'd10; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        abort = 1'b1;
        #1;
        check("ab_beat3", 64'({out_valid, out_data}), {31'd0, 1'b1, ram_word(14'd2)});
        @(negedge clk);
        abort = 1'b0;
        #1;
        check("ab_valid_low", 64'(out_valid), 64'd0);
        check("ab_done", 64'(done), 64'd1);
        check("ab_busy", 64'(busy), 64'd0);
        @(negedge clk);
        #1;
        check("ab_done_once", 64'(done), 64'd0);
        run_xfer(14'd4, 14'd1, 1'b0, 1'b0);
        check("ab_restart_n", 64'(beat_data.size()), 64'd1);
        if (beat_data.size() == 1)
            check("ab_restart_d", 64'(beat_data[0]), 64'(ram_word(14'd4)));
        check("ab_restart_done", 64'(done_cnt), 64'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lab3_qsys_ram_stream_reader.md
LAB3_QSYS_RAM_STREAM_READER -- requirements
Module: lab3_qsys_ram_stream_reader

Interface
REQ-001 SHALL have parameter ADDR_W, default 14, on-chip RAM word-address width.
REQ-002 SHALL have parameter DATA_W, default 32, RAM and stream data width.
REQ-003 SHALL have parameter DEPTH, default 10000, number of RAM words; valid addresses are 0..DEPTH-1.
REQ-004 SHALL have port clk, input, 1: the single clock; all logic on its rising edge.
REQ-005 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port start, input, 1: one-cycle request to begin a transfer.
REQ-007 SHALL have port base_addr, input, ADDR_W: first word address, sampled with start.
REQ-008 SHALL have port length, input, ADDR_W: word count, sampled with start.
REQ-009 SHALL have ports busy (output, 1: transfer active) and done (output, 1: one-cycle completion pulse).
REQ-010 SHALL have ports mem_address (output, ADDR_W), mem_chipselect (output, 1), mem_write (output, 1), mem_byteenable (output, 4) and mem_clken (output, 1): RAM slave drive.
REQ-011 SHALL have port mem_readdata, input, DATA_W: RAM data, valid exactly 1 cycle after an accepted read.
REQ-012 SHALL have ports out_data (output, DATA_W), out_valid (output, 1), out_ready (input, 1), out_sop (output, 1) and out_eop (output, 1): Avalon-ST source.

Function
REQ-013 SHALL tie mem_write=0, mem_byteenable=4'hF and mem_clken=1.
REQ-014 SHALL implement states IDLE, RUN and DRAIN.
REQ-015 SHALL, in IDLE with start=1 and length>0, latch base_addr and length and go to RUN on the next edge; busy=1 from that edge.
REQ-016 SHALL, on start=1 with length=0, stay in IDLE, emit no beats, and pulse done for one cycle on the next edge.
REQ-017 SHALL ignore start while busy=1.
REQ-018 SHALL issue a read (mem_chipselect=1) in RUN only when FIFO occupancy plus in-flight reads is less than 2.
REQ-019 SHALL increment the address after each issued read and wrap DEPTH-1 to 0.
REQ-020 SHALL capture mem_readdata into a 2-entry FIFO on the cycle after each issued read.
REQ-021 SHALL drive out_valid whenever the FIFO is non-empty, and SHALL hold out_data, out_sop and out_eop stable while out_valid=1 and out_ready=0.
REQ-022 SHALL count a beat as transferred when out_valid and out_ready are both 1 in the same cycle.
REQ-023 SHALL assert out_sop on the first beat and out_eop on beat number length; length=1 gives both on one beat.
REQ-024 SHALL move RUN to DRAIN after issuing read number length.
REQ-025 SHALL move DRAIN to IDLE when the last beat is transferred, pulse done in that same cycle, and deassert busy on the next edge.
REQ-026 SHALL reach throughput of 1 beat per cycle with out_ready held high; first out_valid comes 2 cycles after RUN entry.
REQ-027 SHALL keep the FIFO free of overflow and underflow under any out_ready pattern.

Reset
REQ-028 SHALL, with reset_n=0, asynchronously force IDLE, empty the FIFO, clear counters, and drive busy, done, out_valid, out_sop, out_eop and mem_chipselect to 0, and out_data and mem_address to 0.
REQ-029 SHALL abandon a transfer on reset mid-operation, emit no further beats, and issue no done.

Configuration
REQ-030 SHALL, with macro RAM_STREAM_ABORT_EN defined, add input abort, 1: in RUN or DRAIN, abort=1 stops reads, flushes the FIFO, drops out_valid next cycle, pulses done and returns to IDLE; abort is ignored in IDLE.
REQ-031 SHALL, with RAM_STREAM_ABORT_EN undefined, have no abort port and no abort logic.

Verification
REQ-032 SHALL cover: RAM[0..3]=A0..A3, base_addr=0, length=4, out_ready=1 -> beats A0,A1,A2,A3 on consecutive cycles; sop on A0, eop on A3, done once.
REQ-033 SHALL cover: base_addr=9998, length=4 -> reads at addresses 9998, 9999, 0, 1.
REQ-034 SHALL cover: length=8 with out_ready toggling randomly -> 8 beats in order, none lost or duplicated, and at most 2 outstanding.
REQ-035 SHALL cover: length=0 -> no mem_chipselect, no out_valid, done 1 cycle after start; also length=1 -> a single beat with sop=eop=1.
REQ-036 SHALL cover: reset_n pulsed low after beat 2 of 6 -> all outputs 0 at once, and no done.
REQ-037 SHALL cover: with RAM_STREAM_ABORT_EN, abort on beat 3 of 10 -> out_valid low the next cycle, done pulse, and a new start is accepted afterwards.
